// File: rtl/demux_chan_sched_if.sv
// Control/status bundle between a sequencer host and the demux channel scheduler.
// master drives the requests and watches status; slave is the scheduler.
interface demux_chan_sched_if #(
    parameter int unsigned NCH = 8,
    parameter int unsigned DW  = 8
);
    localparam int unsigned SW = $clog2(NCH);

    logic           start;
    logic           abort;
    logic           loop_mode;
    logic [NCH-1:0] chan_mask;
    logic [DW-1:0]  dwell;
    logic           e1;
    logic [SW-1:0]  sel;
    logic [NCH-1:0] chan_onehot;
    logic           busy;
    logic           done;

    modport master (
        output start, abort, loop_mode, chan_mask, dwell,
        input  e1, sel, chan_onehot, busy, done
    );

    modport slave (
        input  start, abort, loop_mode, chan_mask, dwell,
        output e1, sel, chan_onehot, busy, done
    );
endinterface

// File: rtl/demux_chan_sched.sv
// Steers a 1-to-8 demux through the masked channels in ascending order, dwell_r cycles each.
// Define DEMUX_SCHED_GAP_EN to insert a one-cycle e1=0 gap between consecutive channels.
module demux_chan_sched #(
    parameter int unsigned NCH = 8,
    parameter int unsigned DW  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_chan_sched_if.slave   bus
);
    localparam int unsigned SW = $clog2(NCH);

`ifdef DEMUX_SCHED_GAP_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StDwell = 2'd1, StGap = 2'd2, StFin = 2'd3} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StDwell = 2'd1, StFin = 2'd3} state_e;
`endif

    state_e         state_q, state_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic           e1_q, e1_d;
    logic [SW-1:0]  sel_q, sel_d;
    logic [NCH-1:0] onehot_q, onehot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [SW:0]    first_r;
    logic [SW:0]    next_r;
    logic [SW:0]    start_first;
    logic [DW-1:0]  dwell_in;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [SW:0] first_set(input logic [NCH-1:0] m, input logic [SW:0] from);
        logic [SW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) r = {1'b1, i[SW-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        first_r     = first_set(mask_q, '0);
        next_r      = first_set(mask_q, {1'b0, sel_q} + (SW+1)'(1));
        start_first = first_set(bus.chan_mask, '0);
        dwell_in    = (bus.dwell == '0) ? DW'(1) : bus.dwell;
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        e1_d    = e1_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (bus.abort) begin
            // Abort beats start and dwell expiry; sel is left where it was.
            state_d = StIdle;
            e1_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        mask_d  = bus.chan_mask;
                        dwell_d = dwell_in;
                        if (start_first[SW]) begin
                            state_d = StDwell;
                            e1_d    = 1'b1;
                            sel_d   = start_first[SW-1:0];
                            busy_d  = 1'b1;
                            cnt_d   = dwell_in - DW'(1);
                        end else begin
                            state_d = StFin;
                        end
                    end
                end
                StDwell: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DW'(1);
                    end else if (next_r[SW]) begin
                        sel_d = next_r[SW-1:0];
`ifdef DEMUX_SCHED_GAP_EN
                        state_d = StGap;
                        e1_d    = 1'b0;
`else
                        cnt_d = dwell_q - DW'(1);
`endif
                    end else begin
                        state_d = StFin;
                        e1_d    = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = bus.loop_mode && (mask_q != '0);
                    end
                end
`ifdef DEMUX_SCHED_GAP_EN
                StGap: begin
                    state_d = StDwell;
                    e1_d    = 1'b1;
                    cnt_d   = dwell_q - DW'(1);
                end
`endif
                StFin: begin
                    // An empty-mask pass enters FIN without done and pulses it one cycle later.
                    if (!done_q) begin
                        done_d = 1'b1;
                    end else if (busy_q) begin
                        state_d = StDwell;
                        e1_d    = 1'b1;
                        sel_d   = first_r[SW-1:0];
                        cnt_d   = dwell_q - DW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    e1_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end

        onehot_d = e1_d ? ({{(NCH-1){1'b0}}, 1'b1} << sel_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            e1_q     <= 1'b0;
            sel_q    <= '0;
            onehot_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            e1_q     <= e1_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.e1          = e1_q;
    assign bus.sel         = sel_q;
    assign bus.chan_onehot = onehot_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: doc/demux_chan_sched.md
Name: demux_chan_sched

Overview:
- Upstream control stage for the 1-to-8 demultiplexer.
- Generates the demux enable and 3-bit select so a single source is steered through a programmed set of output channels in ascending order.
- Each selected channel is held for a programmable dwell time.
- Supports single-pass and continuous (looping) operation, with a start/abort control interface and busy/done status.

Parameters:
- NCH, 8, number of demux outputs; fixed at 8, select width is 3.
- DW, 8, width of the dwell-count input.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  single-cycle request to begin a pass; ignored while busy=1
- abort  input  1  stop the current sequence
- loop_mode  input  1  1 = restart automatically after each pass
- chan_mask  input  8  channel enable mask, bit i = visit channel i; sampled on accepted start
- dwell  input  DW  cycles each channel is held; sampled on accepted start; 0 treated as 1
- e1  output  1  demux enable
- sel  output  3  demux select, channel index
- chan_onehot  output  8  decoded copy of the active channel, for checking; all-zero when e1=0
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse at the end of a pass

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - e1=0, sel=0, chan_onehot=0, busy=0, done=0.
  - Internal mask, dwell and counter registers cleared; FSM to IDLE.
  - Reset mid-sequence takes effect at that edge; no done pulse is generated.
- All outputs are registered.
- FSM states: IDLE, DWELL, GAP, FIN.
- IDLE:
  - start=1 latches chan_mask→mask_r and max(dwell,1)→dwell_r.
  - If mask_r≠0: next cycle e1=1, sel=lowest set bit index, busy=1, counter=dwell_r-1, go to DWELL. Latency start→e1 is 1 cycle.
  - If mask=0: go to FIN, busy stays 0, e1 stays 0.
- DWELL:
  - counter decrements each cycle. e1/sel stay stable for exactly dwell_r cycles.
  - When counter=0, the next channel is the lowest set bit of mask_r above the current sel; there is no wrap within a pass.
  - If a next channel exists: go to GAP if GAP is compiled in (see Optional Feature), else load sel directly with counter=dwell_r-1. Consecutive channels then have no e1 gap.
  - If no next channel exists: go to FIN with e1=0.
- FIN:
  - done=1 for exactly one cycle, e1=0.
  - If loop_mode=1 and mask_r≠0: restart at the lowest set channel the following cycle. busy stays 1 and mask/dwell are not re-sampled.
  - Otherwise busy=0 and go to IDLE.
- abort=1 in any non-IDLE state:
  - Next cycle e1=0, chan_onehot=0, busy=0, done=0, FSM to IDLE.
  - abort has priority over start and over the dwell expiry in the same cycle.
- start while busy=1 is ignored, including in FIN with loop_mode=1.
- start and abort both asserted in IDLE: abort wins, nothing starts.
- A single-bit mask visits that one channel, then FIN.
- Mask with bit 7 only: sel=7 without wrap.
- sel holds its last value when e1=0; only chan_onehot is zeroed.
- dwell at its maximum (2^DW-1) holds each channel for 2^DW-1 cycles; the counter never underflows.

Optional Feature:
- Macro: DEMUX_SCHED_GAP_EN.
- Defined: a GAP state is inserted between consecutive channels.
  - e1=0 and chan_onehot=0 for exactly one cycle while sel updates to the next channel.
  - e1 rises the following cycle, so sel never changes while e1=1.
  - Per-channel timing is dwell_r cycles on plus 1 cycle off, except after the last channel.
- Not defined: the GAP state and its logic are absent; sel switches directly with e1 held high.

Test Plan:
- Reset, then mask=8'hFF, dwell=2, loop_mode=0, pulse start:
  - e1 rises 1 cycle later and sel steps 0..7, 2 cycles each.
  - done pulses once at cycle 17 after start; busy falls with it.
- mask=8'b1010_0100, dwell=3:
  - sel visits 2,5,7 for 3 cycles each; chan_onehot shows 04,20,80.
  - With DEMUX_SCHED_GAP_EN, 1-cycle e1=0 gaps appear between visits; total pass is 11 cycles.
- mask=0, start:
  - e1 never rises, busy stays 0, done pulses 2 cycles after start.
- dwell=0, mask=8'h01:
  - e1=1 for exactly 1 cycle, then done.
- loop_mode=1, mask=8'h03, dwell=1:
  - Pattern sel 0,1,(done) repeats.
  - start pulses during busy have no effect.
  - abort mid-channel-1 drops e1 and busy next cycle with no done.
- rst_n=0 asserted while sel=4 and e1=1:
  - All outputs are zero after that edge.
  - After release, the FSM stays idle until a new start.
